// File: rtl/fetch_queue.sv
// Prefetch FIFO between the I-cache read port and decode; FLUSH/RST empty it in one cycle.
// Define FETCH_QUEUE_BYPASS_EN to forward an incoming word to the outputs while the queue is empty.
module fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    FLUSH,
    input  logic                    INS_VALID_IN,
    input  logic [31:0]             INSTRUCTION_IN,
    input  logic [ADDR_WIDTH-1:0]   PC_IN,
    output logic                    QUEUE_READY,
    input  logic                    DECODE_ACCEPT,
    output logic [31:0]             INSTRUCTION,
    output logic [ADDR_WIDTH-1:0]   PC_OUT,
    output logic                    INS_VALID_OUT,
    output logic [$clog2(DEPTH):0]  COUNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0]           ins_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_q  [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;

    logic full, empty, push, pop, bypass_take;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // A word consumed straight off the input never touches the array.
    assign bypass_take = empty & INS_VALID_IN & ~FLUSH & DECODE_ACCEPT;
`else
    assign bypass_take = 1'b0;
`endif

    assign push = INS_VALID_IN & ~full & ~FLUSH & ~bypass_take;
    assign pop  = ~empty & DECODE_ACCEPT & ~FLUSH;

    assign QUEUE_READY = ~full;
    assign COUNT       = count_q;

    always_comb begin
        INSTRUCTION   = NOP;
        PC_OUT        = '0;
        INS_VALID_OUT = ~empty;
        if (!empty) begin
            INSTRUCTION = ins_mem_q[rd_ptr_q];
            PC_OUT      = pc_mem_q[rd_ptr_q];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (INS_VALID_IN && !FLUSH) begin
            INSTRUCTION   = INSTRUCTION_IN;
            PC_OUT        = PC_IN;
            INS_VALID_OUT = 1'b1;
        end
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Array contents are left as-is on reset; only the pointers define occupancy.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            ins_mem_q[wr_ptr_q] <= INSTRUCTION_IN;
            pc_mem_q[wr_ptr_q]  <= PC_IN;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/drain, full refusal, steady push+pop, flush, reset, bypass.
module tb_fetch_queue;

    logic        CLK = 1'b0;
    logic        RST, FLUSH, INS_VALID_IN, DECODE_ACCEPT;
    logic [31:0] INSTRUCTION_IN, PC_IN;
    logic        QUEUE_READY, INS_VALID_OUT;
    logic [31:0] INSTRUCTION, PC_OUT;
    logic [2:0]  COUNT;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    fetch_queue #(.DEPTH(4), .ADDR_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .INS_VALID_IN(INS_VALID_IN), .INSTRUCTION_IN(INSTRUCTION_IN), .PC_IN(PC_IN),
        .QUEUE_READY(QUEUE_READY), .DECODE_ACCEPT(DECODE_ACCEPT),
        .INSTRUCTION(INSTRUCTION), .PC_OUT(PC_OUT),
        .INS_VALID_OUT(INS_VALID_OUT), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return 32'hC0DE0000 | pc;
    endfunction

    // Drive inputs just after an edge and let the combinational outputs settle.
    task automatic drive(input logic vin, input logic [31:0] pc, input logic acc, input logic fl);
        INS_VALID_IN   = vin;
        PC_IN          = pc;
        INSTRUCTION_IN = ins_of(pc);
        DECODE_ACCEPT  = acc;
        FLUSH          = fl;
        #1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); step();
        RST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("rst_count", COUNT, 0);
        check("rst_valid", INS_VALID_OUT, 0);
        check("rst_ready", QUEUE_READY, 1);
        check("rst_instr", INSTRUCTION, NOP);
        check("rst_pc", PC_OUT, 0);

        // Fill to full without decode consuming.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            step();
            if (i == 0) begin
                check("fill_lat_valid", INS_VALID_OUT, 1);
                check("fill_lat_pc", PC_OUT, 32'h100);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("full_count", COUNT, 4);
        check("full_ready", QUEUE_READY, 0);
        drive(1'b1, 32'h110, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("drop5_count", COUNT, 4);
        check("drop5_head_pc", PC_OUT, 32'h100);
        check("drop5_head_ins", INSTRUCTION, ins_of(32'h100));

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            check($sformatf("drain_pc%0d", i), PC_OUT, 32'h100 + 32'(4 * i));
            check($sformatf("drain_ins%0d", i), INSTRUCTION, ins_of(32'h100 + 32'(4 * i)));
            step();
        end
        check("drained_valid", INS_VALID_OUT, 0);
        check("drained_instr", INSTRUCTION, NOP);
        check("drained_pc", PC_OUT, 0);
        step();
        check("underflow_count", COUNT, 0);

        // Two-deep steady state with simultaneous push and pop.
        drive(1'b1, 32'h500, 1'b0, 1'b0); step();
        drive(1'b1, 32'h504, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("pp_start_count", COUNT, 2);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h508 + 32'(4 * i), 1'b1, 1'b0);
            check($sformatf("pp_pc%0d", i), PC_OUT, 32'h500 + 32'(4 * i));
            step();
            check($sformatf("pp_count%0d", i), COUNT, 2);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            check($sformatf("pp_tail_pc%0d", i), PC_OUT, 32'h528 + 32'(4 * i));
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("pp_end_count", COUNT, 0);

        // Flush at COUNT=3 with a same-cycle push.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("preflush_count", COUNT, 3);
        drive(1'b1, 32'h200, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("flush_count", COUNT, 0);
        check("flush_valid", INS_VALID_OUT, 0);
        check("flush_instr", INSTRUCTION, NOP);
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("postflush_pc", PC_OUT, 32'h300);
        check("postflush_count", COUNT, 1);

        // Reset mid-stream drops buffered entries.
        drive(1'b1, 32'h304, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("prerst_count", COUNT, 2);
        RST = 1'b1;
        drive(1'b1, 32'h308, 1'b1, 1'b0);
        step();
        RST = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("midrst_count", COUNT, 0);
        check("midrst_ready", QUEUE_READY, 1);
        check("midrst_instr", INSTRUCTION, NOP);

        // Full queue refuses a push even when decode pops the same cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h700 + 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'h710, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("fullpop_count", COUNT, 3);
        check("fullpop_head", PC_OUT, 32'h704);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            check($sformatf("fullpop_drain%0d", i), PC_OUT, 32'h704 + 32'(4 * i));
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("fullpop_empty", COUNT, 0);

        // Empty queue, incoming word with decode ready.
        drive(1'b1, 32'h400, 1'b1, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_valid", INS_VALID_OUT, 1);
        check("byp_pc", PC_OUT, 32'h400);
        check("byp_ins", INSTRUCTION, ins_of(32'h400));
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("byp_count", COUNT, 0);
`else
        check("nobyp_valid", INS_VALID_OUT, 0);
        check("nobyp_instr", INSTRUCTION, NOP);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("nobyp_count", COUNT, 1);
        check("nobyp_pc", PC_OUT, 32'h400);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small prefetch FIFO between the instruction-cache read port and the decode stage.
- Buffers fetched (PC, instruction) pairs so I-cache latency and decode stalls are decoupled.
- Presents the head instruction to decode; decode pops it when it advances.
- FLUSH from a taken branch/jump empties it in one cycle.

Parameters:
- DEPTH, 4, number of entries; power of two, >=2.
- ADDR_WIDTH, 32, PC width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- FLUSH  input  1  discard all entries and any same-cycle push.
- INS_VALID_IN  input  1  I-cache offers a fetched word this cycle.
- INSTRUCTION_IN  input  32  fetched instruction.
- PC_IN  input  ADDR_WIDTH  PC of INSTRUCTION_IN.
- QUEUE_READY  output  1  queue can accept a push (not full).
- DECODE_ACCEPT  input  1  decode consumes head this cycle (decode's stall-enable high, no EX stall).
- INSTRUCTION  output  32  head instruction to decode.
- PC_OUT  output  ADDR_WIDTH  head PC.
- INS_VALID_OUT  output  1  head entry valid.
- COUNT  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry array of {PC, instruction}; write pointer, read pointer ($clog2(DEPTH) bits, wrap modulo DEPTH); occupancy counter.
- push = INS_VALID_IN & QUEUE_READY & !FLUSH.
- pop = INS_VALID_OUT & DECODE_ACCEPT & !FLUSH.
- QUEUE_READY = (COUNT != DEPTH), derived from registered count only. A full queue refuses a push even if a pop occurs the same cycle.
- INS_VALID_OUT = (COUNT != 0).
- INSTRUCTION/PC_OUT come combinationally from the entry at the read pointer.
- When empty, INSTRUCTION = 32'h00000013 (NOP, addi x0,x0,0) and PC_OUT = 0, so decode never sees X.
- Push writes at the write pointer; the write pointer increments, wrapping DEPTH-1 -> 0.
- Pop increments the read pointer with the same wrap.
- Counter update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- Latency (without optional feature): a word pushed into an empty queue is visible at the output the cycle after the push edge (1-cycle latency).
- FLUSH: on the next edge both pointers = 0 and COUNT = 0. A push or pop in the flush cycle is ignored. The next cycle shows INS_VALID_OUT = 0 and INSTRUCTION = NOP.
- RST: identical effect to FLUSH; RST has priority over all other inputs. After reset: COUNT = 0, INS_VALID_OUT = 0, QUEUE_READY = 1, INSTRUCTION = 32'h00000013, PC_OUT = 0.
- Reset asserted mid-stream drops all buffered entries. Array contents need not be cleared, only the pointers and counter.
- DECODE_ACCEPT while empty: no effect. No underflow; the counter never goes below 0 or above DEPTH.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when COUNT == 0 and INS_VALID_IN & !FLUSH, the incoming word is driven combinationally onto the outputs the same cycle:
  - INSTRUCTION = INSTRUCTION_IN, PC_OUT = PC_IN, INS_VALID_OUT = 1.
  - If DECODE_ACCEPT is also high, the word is consumed without being written (COUNT stays 0).
  - Otherwise it is pushed normally.
- Undefined: no bypass; 1-cycle fill latency as above.

Test Plan:
- Reset then idle -> COUNT=0, INS_VALID_OUT=0, QUEUE_READY=1, INSTRUCTION=32'h00000013.
- Push 4 words (PC 0x100..0x10C), DECODE_ACCEPT=0 -> COUNT=4, QUEUE_READY=0. A 5th push (PC 0x110) is dropped. Head stays PC 0x100.
- From full, assert DECODE_ACCEPT for 4 cycles with no pushes -> outputs PC 0x100,0x104,0x108,0x10C in order, then INS_VALID_OUT=0.
- Continuous push+pop for 10 cycles at COUNT=2 -> COUNT stays 2, pointers wrap, PC sequence has no gaps or duplicates.
- COUNT=3, assert FLUSH together with a push of PC 0x200 -> next cycle COUNT=0, INS_VALID_OUT=0. The following push of PC 0x300 appears as head.
- FETCH_QUEUE_BYPASS_EN defined, empty, push PC 0x400 with DECODE_ACCEPT=1 -> same cycle PC_OUT=0x400, INS_VALID_OUT=1; next cycle COUNT=0.
